// File: rtl/complex_mult_arbiter.sv
// Round-robin front end sharing one complex multiplier among NUM_REQ AXI-stream requesters.
// Grant-to-issue latency one cycle; responses are routed in order by a tag FIFO, and a stalled head blocks later beats.
module complex_mult_arbiter #(
  parameter int INTEGER_WIDTH    = 4,
  parameter int FRACTIONAL_WIDTH = 4,
  parameter int NUM_REQ          = 4,
  parameter int TAG_DEPTH        = 8,
  localparam int W    = 2*(INTEGER_WIDTH+FRACTIONAL_WIDTH),
  localparam int P    = 4*(INTEGER_WIDTH+FRACTIONAL_WIDTH),
  localparam int CNTW = $clog2(TAG_DEPTH)+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_tvalid,
  output logic [NUM_REQ-1:0]    req_tready,
  input  logic [NUM_REQ*W-1:0]  req_a_tdata,
  input  logic [NUM_REQ*W-1:0]  req_b_tdata,
  output logic [NUM_REQ-1:0]    rsp_tvalid,
  input  logic [NUM_REQ-1:0]    rsp_tready,
  output logic [P-1:0]          rsp_tdata,
  output logic                  mult_a_tvalid,
  input  logic                  mult_a_tready,
  output logic [W-1:0]          mult_a_tdata,
  output logic                  mult_b_tvalid,
  input  logic                  mult_b_tready,
  output logic [W-1:0]          mult_b_tdata,
  input  logic                  mult_prod_tvalid,
  output logic                  mult_prod_tready,
  input  logic [P-1:0]          mult_prod_tdata,
  output logic [CNTW-1:0]       inflight,
  output logic                  orphan_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TAG_DEPTH);
  localparam logic [IDW:0]    NREQ_X  = (IDW+1)'(NUM_REQ);
  localparam logic [CNTW-1:0] DEPTH_X = CNTW'(TAG_DEPTH);

  typedef enum logic {ARB, ISSUE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id_hold;
  logic [W-1:0]    r_a_hold;
  logic [W-1:0]    r_b_hold;
  logic            r_a_sent;
  logic            r_b_sent;
  logic            r_orphan;
  logic [IDW-1:0]  r_tag_mem [TAG_DEPTH];
  logic [TW-1:0]   r_wr_ptr;
  logic [TW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  logic            w_grant_vld;
  logic [IDW-1:0]  w_grant_id;
  logic            w_grant;
  logic            w_a_hs;
  logic            w_b_hs;
  logic            w_issue_done;
  logic            w_empty;
  logic            w_pop;
  logic [IDW-1:0]  w_head;

  function automatic logic [IDW-1:0] f_wrap(input logic [IDW:0] v);
    logic [IDW:0] t;
    t = (v >= NREQ_X) ? (v - NREQ_X) : v;
    return t[IDW-1:0];
  endfunction

  // Scan from farthest to nearest so the requester closest after r_rr_ptr wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_tvalid[f_wrap({1'b0, r_rr_ptr} + (IDW+1)'(k))]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = f_wrap({1'b0, r_rr_ptr} + (IDW+1)'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    req_tready    = '0;
    mult_a_tvalid = 1'b0;
    mult_b_tvalid = 1'b0;
    w_issue_done  = 1'b0;
    case (r_state)
      ARB: begin
        if (w_grant_vld && (r_count < DEPTH_X)) begin
          w_grant                = 1'b1;
          req_tready[w_grant_id] = 1'b1;
          w_state_nxt            = ISSUE;
        end
      end
      ISSUE: begin
        mult_a_tvalid = !r_a_sent;
        mult_b_tvalid = !r_b_sent;
        if ((r_a_sent || mult_a_tready) && (r_b_sent || mult_b_tready)) begin
          w_issue_done = 1'b1;
          w_state_nxt  = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  assign w_a_hs       = mult_a_tvalid && mult_a_tready;
  assign w_b_hs       = mult_b_tvalid && mult_b_tready;
  assign mult_a_tdata = r_a_hold;
  assign mult_b_tdata = r_b_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= IDW'(NUM_REQ-1);
      r_id_hold <= '0;
      r_a_hold  <= '0;
      r_b_hold  <= '0;
      r_a_sent  <= 1'b0;
      r_b_sent  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_a_hold  <= req_a_tdata[int'(w_grant_id)*W +: W];
        r_b_hold  <= req_b_tdata[int'(w_grant_id)*W +: W];
        r_id_hold <= w_grant_id;
        r_rr_ptr  <= w_grant_id;
      end
      if (w_issue_done) begin
        r_a_sent <= 1'b0;
        r_b_sent <= 1'b0;
      end else begin
        if (w_a_hs) r_a_sent <= 1'b1;
        if (w_b_hs) r_b_sent <= 1'b1;
      end
    end
  end

  // Tag FIFO: only one pair is ever held, and grants stop at full, so no overflow guard is needed.
  assign w_empty = (r_count == '0);
  assign w_head  = r_tag_mem[r_rd_ptr];
  assign w_pop   = !w_empty && mult_prod_tvalid && rsp_tready[w_head];

  always_ff @(posedge clk) begin
    if (w_issue_done) begin
      r_tag_mem[r_wr_ptr] <= r_id_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_issue_done) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_issue_done && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_issue_done) begin
        r_count <= r_count - 1'b1;
      end
      if (w_empty && mult_prod_tvalid) r_orphan <= 1'b1;
    end
  end

  // With no tag outstanding the beat is swallowed so the multiplier can never wedge.
  always_comb begin
    rsp_tvalid       = '0;
    mult_prod_tready = 1'b1;
    if (!w_empty) begin
      rsp_tvalid[w_head] = mult_prod_tvalid;
      mult_prod_tready   = rsp_tready[w_head];
    end
  end

  assign rsp_tdata  = mult_prod_tdata;
  assign inflight   = r_count;
  assign orphan_err = r_orphan;

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Bench for complex_mult_arbiter: directed scenarios plus a randomized run against a queue-based reference.
module tb_complex_mult_arbiter;
  localparam int IW = 4, FW = 4, NR = 4, TD = 8;
  localparam int CW = IW+FW, W = 2*CW, P = 4*CW, CNTW = $clog2(TD)+1;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] req_tvalid, req_tready, rsp_tvalid, rsp_tready;
  logic [NR*W-1:0] req_a_tdata, req_b_tdata;
  logic [P-1:0] rsp_tdata, mult_prod_tdata;
  logic mult_a_tvalid, mult_a_tready, mult_b_tvalid, mult_b_tready;
  logic mult_prod_tvalid, mult_prod_tready;
  logic [W-1:0] mult_a_tdata, mult_b_tdata;
  logic [CNTW-1:0] inflight;
  logic orphan_err;

  complex_mult_arbiter #(.INTEGER_WIDTH(IW), .FRACTIONAL_WIDTH(FW), .NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready),
    .req_a_tdata(req_a_tdata), .req_b_tdata(req_b_tdata),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
    .mult_a_tvalid(mult_a_tvalid), .mult_a_tready(mult_a_tready), .mult_a_tdata(mult_a_tdata),
    .mult_b_tvalid(mult_b_tvalid), .mult_b_tready(mult_b_tready), .mult_b_tdata(mult_b_tdata),
    .mult_prod_tvalid(mult_prod_tvalid), .mult_prod_tready(mult_prod_tready),
    .mult_prod_tdata(mult_prod_tdata),
    .inflight(inflight), .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [P-1:0] prod; } exp_t;
  typedef struct { logic [P-1:0] prod; int rdy; } pipe_t;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  // stimulus knobs (percent probabilities and budgets)
  int p_req = 0, p_a = 100, p_b = 100, p_out = 100, p_rsp = 100, lat = 3, lat_rand = 0;
  int gen_budget = 0, out_budget = 1000000;
  logic [NR-1:0] gen_mask = '0, rsp_force_val = '0;
  bit rsp_force = 0, model_en = 1;
  // reference state
  exp_t exp_q[$];
  pipe_t pq[$];
  logic [W-1:0] mqa[$], mqb[$];
  int m_inflight = 0, last_grant = NR-1, grants = 0;
  bit m_orphan = 0, prod_popped = 0;
  int grant_log[$];
  int delivered[NR];
  int n_ahs = 0, n_bhs = 0, acc_cyc = -1, a_hs_cyc = -1, last_rsp_lane = -1;
  logic [W-1:0] a_hs_dat, b_hs_dat;
  logic [P-1:0] last_rsp_dat;
  bit a_pend = 0, b_pend = 0;
  logic [W-1:0] a_pend_dat, b_pend_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference complex product: Q(I.F) x Q(I.F) gives a full-precision Q(2I.2F) per component.
  function automatic logic [P-1:0] cmul(input logic [W-1:0] a, input logic [W-1:0] b);
    int ar, ai, br, bi, re, im;
    ar = $signed(a[W-1:CW]); ai = $signed(a[CW-1:0]);
    br = $signed(b[W-1:CW]); bi = $signed(b[CW-1:0]);
    re = ar*br - ai*bi;
    im = ar*bi + ai*br;
    return {re[2*CW-1:0], im[2*CW-1:0]};
  endfunction

  function automatic int rr_expect(input int lg, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(lg+k) % NR]) return (lg+k) % NR;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [NR-1:0] acc_mask, oh;
    int hid;
    logic [W-1:0] ta, tb;
    acc_mask = '0;
    if (!rst) begin
      chk("inflight", inflight, m_inflight);
      chk("orphan_err", orphan_err, m_orphan);
      chk("req_tready_onehot0", $onehot0(req_tready), 1);
      chk("rsp_tvalid_onehot0", $onehot0(rsp_tvalid), 1);
      if (a_pend) begin chk("a_hold_vld", mult_a_tvalid, 1); chk("a_hold_dat", mult_a_tdata, a_pend_dat); end
      if (b_pend) begin chk("b_hold_vld", mult_b_tvalid, 1); chk("b_hold_dat", mult_b_tdata, b_pend_dat); end
      for (int i = 0; i < NR; i++) begin
        if (req_tvalid[i] && req_tready[i]) begin
          chk("rr_grant", i, rr_expect(last_grant, req_tvalid));
          chk("grant_not_full", (m_inflight < TD), 1);
          exp_q.push_back('{i, cmul(req_a_tdata[i*W +: W], req_b_tdata[i*W +: W])});
          last_grant = i; grants++; grant_log.push_back(i); acc_cyc = cyc;
          acc_mask[i] = 1'b1;
        end
      end
      if (m_inflight == 0) begin
        chk("empty_prod_rdy", mult_prod_tready, 1);
        chk("empty_rsp_vld", rsp_tvalid, 0);
        if (mult_prod_tvalid) m_orphan = 1;
      end else if (mult_prod_tvalid) begin
        hid = exp_q[0].id;
        oh = '0; oh[hid] = 1'b1;
        chk("rsp_vld_head", rsp_tvalid, oh);
        chk("prod_rdy_head", mult_prod_tready, rsp_tready[hid]);
        if (mult_prod_tready) begin
          chk("rsp_dat", rsp_tdata, exp_q[0].prod);
          last_rsp_dat = rsp_tdata; last_rsp_lane = hid;
          delivered[hid]++;
          void'(exp_q.pop_front());
          m_inflight--;
        end
      end else begin
        chk("rsp_vld_idle", rsp_tvalid, 0);
      end
      prod_popped = 0;
      if (model_en && mult_prod_tvalid && mult_prod_tready && pq.size() > 0) begin
        void'(pq.pop_front()); prod_popped = 1; out_budget--;
      end
      if (mult_a_tvalid && mult_a_tready) begin
        mqa.push_back(mult_a_tdata); n_ahs++; a_hs_cyc = cyc; a_hs_dat = mult_a_tdata;
      end
      if (mult_b_tvalid && mult_b_tready) begin
        mqb.push_back(mult_b_tdata); n_bhs++; b_hs_dat = mult_b_tdata;
      end
      a_pend = mult_a_tvalid && !mult_a_tready; a_pend_dat = mult_a_tdata;
      b_pend = mult_b_tvalid && !mult_b_tready; b_pend_dat = mult_b_tdata;
      while (mqa.size() > 0 && mqb.size() > 0) begin
        ta = mqa.pop_front(); tb = mqb.pop_front();
        pq.push_back('{cmul(ta, tb), cyc + (lat_rand ? int'($urandom_range(1, 6)) : lat)});
        m_inflight++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < NR; i++) if (acc_mask[i]) req_tvalid[i] = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (gen_mask[i] && !req_tvalid[i] && gen_budget > 0 && $urandom_range(99) < p_req) begin
          req_a_tdata[i*W +: W] = W'($urandom);
          req_b_tdata[i*W +: W] = W'($urandom);
          req_tvalid[i] = 1'b1;
          gen_budget--;
        end
      end
      mult_a_tready = ($urandom_range(99) < p_a);
      mult_b_tready = ($urandom_range(99) < p_b);
      for (int i = 0; i < NR; i++) rsp_tready[i] = rsp_force ? rsp_force_val[i] : ($urandom_range(99) < p_rsp);
      if (model_en) begin
        if (!(mult_prod_tvalid && !prod_popped)) begin
          mult_prod_tvalid = (pq.size() > 0) && (pq.size() > 0 ? pq[0].rdy <= cyc : 1'b0)
                             && (out_budget > 0) && ($urandom_range(99) < p_out);
        end
        if (mult_prod_tvalid) mult_prod_tdata = pq[0].prod;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_tvalid = '0; mult_prod_tvalid = 1'b0; gen_budget = 0;
    #1;
    cycle();
    mqa.delete(); mqb.delete(); pq.delete(); exp_q.delete();
    m_inflight = 0; m_orphan = 0; last_grant = NR-1; a_pend = 0; b_pend = 0; prod_popped = 0;
    rst = 1'b0;
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req_tready"}, req_tready, 0);
    chk({tag, "_mult_a_vld"}, mult_a_tvalid, 0);
    chk({tag, "_mult_b_vld"}, mult_b_tvalid, 0);
    chk({tag, "_rsp_vld"}, rsp_tvalid, 0);
    chk({tag, "_inflight"}, inflight, 0);
    chk({tag, "_orphan"}, orphan_err, 0);
  endtask

  initial begin
    int g0, d1, d3, tot0, tot;
    logic [P-1:0] exp_prod;
    int rr_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst = 1'b1; req_tvalid = '0; req_a_tdata = '0; req_b_tdata = '0; rsp_tready = '1;
    mult_a_tready = 1'b1; mult_b_tready = 1'b1; mult_prod_tvalid = 1'b0; mult_prod_tdata = '0;
    for (int i = 0; i < NR; i++) delivered[i] = 0;
    do_reset();
    do_reset();
    check_idle("reset");
    chk("reset_prod_rdy", mult_prod_tready, 1);

    // Single request from requester 2
    g0 = grants;
    req_a_tdata[2*W +: W] = 16'h1020; req_b_tdata[2*W +: W] = 16'h30F0; req_tvalid[2] = 1'b1;
    #1;
    repeat (15) cycle();
    chk("single_grants", grants - g0, 1);
    chk("single_a_dat", a_hs_dat, 16'h1020);
    chk("single_b_dat", b_hs_dat, 16'h30F0);
    chk("single_issue_lat", a_hs_cyc - acc_cyc, 1);
    exp_prod = 32'h0500_0500;
    chk("single_prod", last_rsp_dat, exp_prod);
    chk("single_lane", last_rsp_lane, 2);
    chk("single_inflight", inflight, 0);

    // Round-robin with all requesters continuously valid for eight grants
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NR; i++) delivered[i] = 0;
    gen_mask = '1; p_req = 100; gen_budget = 8;
    repeat (60) cycle();
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, rr_seq[i]);
    for (int i = 0; i < NR; i++) chk("rr_lane_count", delivered[i], 2);

    // Skewed multiplier ready: a accepted at once, b stalled three cycles
    gen_mask = '0; p_b = 0; g0 = n_ahs; d1 = n_bhs;
    req_a_tdata[1*W +: W] = 16'h7F81; req_b_tdata[1*W +: W] = 16'h0A55; req_tvalid[1] = 1'b1;
    #1;
    repeat (3) cycle();
    chk("skew_a_once", n_ahs - g0, 1);
    chk("skew_b_vld", mult_b_tvalid, 1);
    chk("skew_b_dat", mult_b_tdata, 16'h0A55);
    chk("skew_a_vld_low", mult_a_tvalid, 0);
    chk("skew_no_tag_yet", inflight, 0);
    p_b = 100;
    cycle();
    chk("skew_still_no_tag", inflight, 0);
    cycle();
    chk("skew_tag_pushed", inflight, 1);
    chk("skew_b_once", n_bhs - d1, 1);
    chk("skew_a_total", n_ahs - g0, 1);
    repeat (10) cycle();

    // Back-pressure: products never return, requester 0 always valid
    out_budget = 0; gen_mask = 4'b0001; p_req = 100; gen_budget = 9; g0 = grants;
    repeat (60) cycle();
    chk("bp_grants", grants - g0, 8);
    chk("bp_inflight", inflight, 8);
    chk("bp_tready_low", req_tready, 0);
    chk("bp_req_pending", req_tvalid[0], 1);
    out_budget = 1;
    repeat (30) cycle();
    chk("bp_release_grants", grants - g0, 9);
    chk("bp_release_inflight", inflight, 8);
    out_budget = 1000000;
    repeat (80) cycle();
    chk("bp_drain", inflight, 0);

    // Head blocking: requester 1 then 3 in flight, lane 1 stalled
    out_budget = 0; gen_mask = 4'b1010; gen_budget = 2; grant_log.delete();
    repeat (20) cycle();
    chk("hb_order0", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    chk("hb_order1", grant_log.size() > 1 ? grant_log[1] : -1, 3);
    chk("hb_inflight", inflight, 2);
    d1 = delivered[1]; d3 = delivered[3];
    rsp_force = 1; rsp_force_val = 4'b1000; out_budget = 1000000;
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("hb_prod_rdy_low", mult_prod_tready, 0);
      chk("hb_rsp_vld", rsp_tvalid, 4'b0010);
      cycle();
    end
    chk("hb_lane3_waiting", delivered[3] - d3, 0);
    rsp_force_val = 4'b1010;
    repeat (10) cycle();
    chk("hb_lane1_done", delivered[1] - d1, 1);
    chk("hb_lane3_done", delivered[3] - d3, 1);
    chk("hb_inflight_done", inflight, 0);
    rsp_force = 0;

    // Randomized traffic against the reference
    do_reset();
    tot0 = 0; for (int i = 0; i < NR; i++) tot0 += delivered[i];
    p_a = 70; p_b = 60; p_out = 70; p_rsp = 70; p_req = 40; lat_rand = 1;
    gen_mask = '1; gen_budget = 300;
    for (int t = 0; t < 6000; t++) begin
      if (gen_budget == 0 && req_tvalid == '0 && exp_q.size() == 0) break;
      cycle();
    end
    tot = 0; for (int i = 0; i < NR; i++) tot += delivered[i];
    chk("rand_delivered", tot - tot0, 300);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_inflight", inflight, 0);
    p_a = 100; p_b = 100; p_out = 100; p_rsp = 100; p_req = 0; lat_rand = 0; gen_mask = '0;

    // Orphan beat, then reset in the middle of an issue
    model_en = 0;
    chk("orphan_before", orphan_err, 0);
    mult_prod_tvalid = 1'b1; mult_prod_tdata = 32'hDEAD_BEEF;
    #1;
    cycle();
    mult_prod_tvalid = 1'b0;
    #1;
    chk("orphan_set", orphan_err, 1);
    p_b = 0;
    req_a_tdata[0 +: W] = 16'h1111; req_b_tdata[0 +: W] = 16'h2222; req_tvalid[0] = 1'b1;
    #1;
    cycle();
    cycle();
    chk("issue_b_pending", mult_b_tvalid, 1);
    do_reset();
    check_idle("midreset");
    cycle();
    chk("post_reset_no_issue", mult_b_tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
